// File: rtl/msg_fifo_unloader_pkg.sv
// Shared types and sizes for the receive-side message FIFO unloader.
package msg_fifo_unloader_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned DATA_DEPTH = 512;
  localparam int unsigned ENTRY_W    = WORD_W + 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    POP_LEN  = 3'd1,
    LOAD_LEN = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sop;
    logic              eop;
  } tx_word_t;

endpackage

// File: rtl/msg_fifo_unloader_word_skid_buf.sv
// Two-entry output buffer holding message words with their sop/eop tags.
module msg_fifo_unloader_word_skid_buf
  import msg_fifo_unloader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_i,
  input  tx_word_t   wdata_i,
  input  logic       rd_i,
  output tx_word_t   rdata_o,
  output logic [1:0] occupancy_o
);

  tx_word_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic       do_wr;
  logic       do_rd;

  // A write into a full buffer is only taken when a pop frees a slot the same cycle.
  assign do_rd = rd_i && (cnt_q != 2'd0);
  assign do_wr = wr_i && ((cnt_q != 2'd2) || do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_rd) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(do_wr) - 2'(do_rd);
    end
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign occupancy_o = cnt_q;

endmodule

// File: rtl/msg_fifo_unloader.sv
// Pops one length per message from the length FIFO, drains that many words from
// the data FIFO and presents them on a valid/ready stream with sop/eop markers.
module msg_fifo_unloader
  import msg_fifo_unloader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_W    = 10
) (
  input  logic              RST,
  input  logic              RX_CLK,
  input  logic              LEN_EMPTY,
  input  logic [LEN_W-1:0]  LEN_Q,
  output logic              LEN_RDREQ,
  input  logic              DATA_EMPTY,
  input  logic [WORD_W-1:0] DATA_Q,
  output logic              DATA_RDREQ,
  input  logic              TX_READY,
  output logic              TX_VALID,
  output logic [WORD_W-1:0] TX_DATA,
  output logic              TX_SOP,
  output logic              TX_EOP,
  output logic [7:0]        MSG_COUNT,
  output logic              ERR_LEN,
  output logic              ERR_UNDERRUN,
  output logic [2:0]        state_mon
);

  state_e            state_q;
  logic [LEN_W-1:0]  words_left_q;
  logic              sop_pending_q;
  logic              inflight_q;
  logic              infl_sop_q;
  logic              infl_eop_q;
  logic [TO_W-1:0]   to_q;
  logic              len_rdreq_q;
  logic [7:0]        msg_count_q;
  logic              err_len_q;
  logic              err_underrun_q;

  tx_word_t          head;
  tx_word_t          wdata;
  logic [1:0]        occ;
  logic [2:0]        level;
  logic              pop;
  logic              fetch;
  logic              stalled;
  logic              abort;
  logic              buf_wr;

  assign TX_VALID = (occ != 2'd0);
  assign pop      = TX_VALID && TX_READY;

  // Level counts the slot freed by this cycle's pop so a steady stream runs at one word per cycle.
  assign level   = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign fetch   = (state_q == STREAM) && !DATA_EMPTY && (words_left_q != '0) && (level < 3'd2);
  assign stalled = (state_q == STREAM) && (words_left_q != '0) && DATA_EMPTY;
  assign abort   = stalled && (to_q == TO_W'(TIMEOUT - 32'd1));
  assign buf_wr  = inflight_q && !abort;
  assign wdata   = {DATA_Q, infl_sop_q, infl_eop_q};

  msg_fifo_unloader_word_skid_buf u_buf (
    .clk         (RX_CLK),
    .rst_n       (RST),
    .wr_i        (buf_wr),
    .wdata_i     (wdata),
    .rd_i        (pop),
    .rdata_o     (head),
    .occupancy_o (occ)
  );

  // Message sequencing, fetch bookkeeping, timeout and status counters.
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      words_left_q   <= '0;
      sop_pending_q  <= 1'b0;
      inflight_q     <= 1'b0;
      infl_sop_q     <= 1'b0;
      infl_eop_q     <= 1'b0;
      to_q           <= '0;
      len_rdreq_q    <= 1'b0;
      msg_count_q    <= 8'd0;
      err_len_q      <= 1'b0;
      err_underrun_q <= 1'b0;
    end else begin
      len_rdreq_q    <= 1'b0;
      err_len_q      <= 1'b0;
      err_underrun_q <= 1'b0;
      inflight_q     <= fetch;
      infl_sop_q     <= fetch && sop_pending_q;
      infl_eop_q     <= fetch && (words_left_q == LEN_W'(1));
      if (stalled && !abort) begin
        to_q <= to_q + TO_W'(1);
      end else begin
        to_q <= '0;
      end
      if (fetch) begin
        words_left_q  <= words_left_q - LEN_W'(1);
        sop_pending_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          // Leftover words of an aborted message drain before the next length is popped.
          if (!LEN_EMPTY && (occ == 2'd0)) begin
            len_rdreq_q <= 1'b1;
            state_q     <= POP_LEN;
          end
        end
        POP_LEN: begin
          state_q <= LOAD_LEN;
        end
        LOAD_LEN: begin
          words_left_q  <= LEN_Q;
          sop_pending_q <= 1'b1;
          if (LEN_Q == '0) begin
            err_len_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (abort) begin
            words_left_q   <= '0;
            sop_pending_q  <= 1'b0;
            err_underrun_q <= 1'b1;
            state_q        <= IDLE;
          end else if (fetch && (words_left_q == LEN_W'(1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.eop) begin
            msg_count_q <= msg_count_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign LEN_RDREQ    = len_rdreq_q;
  assign DATA_RDREQ   = fetch;
  assign TX_DATA      = head.data;
  assign TX_SOP       = head.sop;
  assign TX_EOP       = head.eop;
  assign MSG_COUNT    = msg_count_q;
  assign ERR_LEN      = err_len_q;
  assign ERR_UNDERRUN = err_underrun_q;
  assign state_mon    = state_q;

endmodule

// File: tb/tb_msg_fifo_unloader.sv
// Scoreboard bench for msg_fifo_unloader with behavioural length/data FIFO models.
module tb_msg_fifo_unloader;
  import msg_fifo_unloader_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        e;
  } exp_t;

  logic        RST;
  logic        RX_CLK;
  logic        LEN_EMPTY;
  logic [7:0]  LEN_Q = '0;
  logic        LEN_RDREQ;
  logic        DATA_EMPTY;
  logic [15:0] DATA_Q = '0;
  logic        DATA_RDREQ;
  logic        TX_READY;
  logic        TX_VALID;
  logic [15:0] TX_DATA;
  logic        TX_SOP;
  logic        TX_EOP;
  logic [7:0]  MSG_COUNT;
  logic        ERR_LEN;
  logic        ERR_UNDERRUN;
  logic [2:0]  state_mon;

  int total  = 0;
  int bad    = 0;
  int beats  = 0;
  int rdreqs = 0;
  exp_t sb[$];

  logic [7:0]  len_mem [1024];
  logic [15:0] dat_mem [1024];
  int len_wp = 0;
  int len_rp = 0;
  int dat_wp = 0;
  int dat_rp = 0;

  msg_fifo_unloader #(.TIMEOUT(8), .TO_W(10)) dut (
    .RST          (RST),
    .RX_CLK       (RX_CLK),
    .LEN_EMPTY    (LEN_EMPTY),
    .LEN_Q        (LEN_Q),
    .LEN_RDREQ    (LEN_RDREQ),
    .DATA_EMPTY   (DATA_EMPTY),
    .DATA_Q       (DATA_Q),
    .DATA_RDREQ   (DATA_RDREQ),
    .TX_READY     (TX_READY),
    .TX_VALID     (TX_VALID),
    .TX_DATA      (TX_DATA),
    .TX_SOP       (TX_SOP),
    .TX_EOP       (TX_EOP),
    .MSG_COUNT    (MSG_COUNT),
    .ERR_LEN      (ERR_LEN),
    .ERR_UNDERRUN (ERR_UNDERRUN),
    .state_mon    (state_mon)
  );

  initial begin
    RX_CLK = 1'b0;
    forever #5 RX_CLK = ~RX_CLK;
  end

  // Normal-mode FIFOs: q updates one cycle after the read request.
  assign LEN_EMPTY  = (len_wp == len_rp);
  assign DATA_EMPTY = (dat_wp == dat_rp);
  always @(posedge RX_CLK) begin
    if (LEN_RDREQ && (len_rp != len_wp)) begin
      LEN_Q  <= len_mem[len_rp[9:0]];
      len_rp <= len_rp + 1;
    end
    if (DATA_RDREQ && (dat_rp != dat_wp)) begin
      DATA_Q <= dat_mem[dat_rp[9:0]];
      dat_rp <= dat_rp + 1;
    end
  end

  task automatic load_len(input int len);
    len_mem[len_wp[9:0]] = 8'(len);
    len_wp++;
  endtask

  task automatic load_word(input logic [15:0] w, input logic s, input logic e);
    dat_mem[dat_wp[9:0]] = w;
    dat_wp++;
    sb.push_back('{d: w, s: s, e: e});
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge RX_CLK);
      if ((sb.size() == 0) && (state_mon == 3'd0) && LEN_EMPTY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic monitor();
    logic        stall = 1'b0;
    logic [17:0] held  = '0;
    exp_t        e;
    forever begin
      @(negedge RX_CLK);
      if (DATA_RDREQ) rdreqs++;
      total++;
      if (dut.u_buf.occupancy_o > 2'd2) begin
        bad++;
        $display("FAIL occupancy: got %0d, limit 2", dut.u_buf.occupancy_o);
      end
      if (stall && RST) begin
        total++;
        if ({TX_VALID, TX_DATA, TX_SOP, TX_EOP} !== {1'b1, held}) begin
          bad++;
          $display("FAIL stall_stable: got v=%b %h/%b/%b, held %h/%b/%b",
                   TX_VALID, TX_DATA, TX_SOP, TX_EOP, held[17:2], held[1], held[0]);
        end
      end
      stall = RST && TX_VALID && !TX_READY;
      held  = {TX_DATA, TX_SOP, TX_EOP};
      if (RST && TX_VALID && TX_READY) begin
        beats++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL beat: unexpected word %h sop=%b eop=%b", TX_DATA, TX_SOP, TX_EOP);
        end else begin
          e = sb.pop_front();
          if ({TX_DATA, TX_SOP, TX_EOP} !== e) begin
            bad++;
            $display("FAIL beat: got %h sop=%b eop=%b, want %h sop=%b eop=%b",
                     TX_DATA, TX_SOP, TX_EOP, e.d, e.s, e.e);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    RST      = 1'b0;
    TX_READY = 1'b0;
    repeat (3) @(posedge RX_CLK);
    #1;
    total++;
    if ({LEN_RDREQ, DATA_RDREQ, TX_VALID, TX_DATA, TX_SOP, TX_EOP, MSG_COUNT,
         ERR_LEN, ERR_UNDERRUN, state_mon} !== 36'd0) begin
      bad++;
      $display("FAIL reset: outputs nonzero, tx_data=%h count=%0d state=%0d", TX_DATA, MSG_COUNT, state_mon);
    end
    @(posedge RX_CLK);
    #1 RST = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] c0 = MSG_COUNT;
    int lr = 0;
    int bc[$];
    logic ok = 1'b0;
    @(posedge RX_CLK);
    #1;
    TX_READY = 1'b1;
    load_len(3);
    load_word(16'h55AA, 1'b1, 1'b0);
    load_word(16'h0140, 1'b0, 1'b0);
    load_word(16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge RX_CLK);
      if (LEN_RDREQ) lr++;
      if (TX_VALID && TX_READY) bc.push_back(i);
      if ((sb.size() == 0) && (state_mon == 3'd0) && LEN_EMPTY) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: got not done, want done"); end
    total++;
    if (lr != 1) begin bad++; $display("FAIL basic_len_rdreq: got %0d cycles, want 1", lr); end
    total++;
    if (bc.size() != 3) begin
      bad++;
      $display("FAIL basic_beats: got %0d beats, want 3", bc.size());
    end else if (bc[2] - bc[0] != 2) begin
      bad++;
      $display("FAIL basic_consecutive: got span %0d, want 2", bc[2] - bc[0]);
    end
    total++;
    if (MSG_COUNT !== c0 + 8'd1) begin
      bad++;
      $display("FAIL basic_count: got %0d, want %0d", MSG_COUNT, c0 + 8'd1);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] c0 = MSG_COUNT;
    int r0 = rdreqs;
    logic ok = 1'b0;
    load_len(4);
    for (int i = 0; i < 4; i++) load_word(16'hA500 + 16'(i), i == 0, i == 3);
    for (int i = 0; i < 200; i++) begin
      @(posedge RX_CLK);
      #1;
      TX_READY = ((i % 4) == 0) || ((i % 4) == 3);
      @(negedge RX_CLK);
      if ((sb.size() == 0) && (state_mon == 3'd0) && LEN_EMPTY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge RX_CLK);
    #1;
    TX_READY = 1'b1;
    total++;
    if (!ok) begin bad++; $display("FAIL bp_timeout: got not done, want done"); end
    total++;
    if (rdreqs - r0 != 4) begin bad++; $display("FAIL bp_rdreq: got %0d, want 4", rdreqs - r0); end
    total++;
    if (MSG_COUNT !== c0 + 8'd1) begin
      bad++;
      $display("FAIL bp_count: got %0d, want %0d", MSG_COUNT, c0 + 8'd1);
    end
  endtask

  task automatic test_single();
    logic [7:0] c0 = MSG_COUNT;
    int b0 = beats;
    logic ok;
    load_len(1);
    load_word(16'hFF00, 1'b1, 1'b1);
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout: got not done, want done"); end
    total++;
    if (beats - b0 != 1) begin bad++; $display("FAIL single_beats: got %0d, want 1", beats - b0); end
    total++;
    if (MSG_COUNT !== c0 + 8'd1) begin
      bad++;
      $display("FAIL single_count: got %0d, want %0d", MSG_COUNT, c0 + 8'd1);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] c0 = MSG_COUNT;
    int err_n = 0;
    int err_at = -1;
    int rq[$];
    int tx_early = 0;
    logic ok = 1'b0;
    load_len(0);
    load_len(2);
    load_word(16'hA0A0, 1'b1, 1'b0);
    load_word(16'hA0A1, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge RX_CLK);
      if (ERR_LEN) begin err_n++; if (err_at < 0) err_at = i; end
      if (LEN_RDREQ) rq.push_back(i);
      if (TX_VALID && (rq.size() < 2)) tx_early++;
      if ((sb.size() == 0) && (state_mon == 3'd0) && LEN_EMPTY) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL zero_timeout: got not done, want done"); end
    total++;
    if (err_n != 1) begin bad++; $display("FAIL zero_err_len: got %0d pulse cycles, want 1", err_n); end
    total++;
    if (tx_early != 0) begin bad++; $display("FAIL zero_tx: got %0d valid cycles, want 0", tx_early); end
    total++;
    if (rq.size() != 2) begin
      bad++;
      $display("FAIL zero_pops: got %0d length pops, want 2", rq.size());
    end else if (rq[1] - err_at != 1) begin
      bad++;
      $display("FAIL zero_next_pop: got %0d cycles after ERR_LEN, want 1", rq[1] - err_at);
    end
    total++;
    if (MSG_COUNT !== c0 + 8'd1) begin
      bad++;
      $display("FAIL zero_count: got %0d, want %0d", MSG_COUNT, c0 + 8'd1);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] c0 = MSG_COUNT;
    int fq[$];
    int eq[$];
    logic [2:0] st_at_err = 3'd7;
    logic ok = 1'b0;
    load_len(5);
    load_word(16'hB000, 1'b1, 1'b0);
    load_word(16'hB001, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge RX_CLK);
      if (DATA_RDREQ) fq.push_back(i);
      if (ERR_UNDERRUN) begin
        if (eq.size() == 0) st_at_err = state_mon;
        eq.push_back(i);
      end
      if ((eq.size() != 0) && (sb.size() == 0) && (state_mon == 3'd0)) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL underrun_timeout: got not done, want done"); end
    total++;
    if (fq.size() != 2) begin bad++; $display("FAIL underrun_fetches: got %0d, want 2", fq.size()); end
    total++;
    if (eq.size() != 1) begin
      bad++;
      $display("FAIL underrun_pulse: got %0d cycles, want 1", eq.size());
    end else if ((fq.size() == 2) && ((eq[0] - fq[1] < 9) || (eq[0] - fq[1] > 10))) begin
      bad++;
      $display("FAIL underrun_delay: got %0d cycles after 2nd fetch, want 9..10", eq[0] - fq[1]);
    end
    total++;
    if (st_at_err !== 3'd0) begin bad++; $display("FAIL underrun_state: got %0d, want 0", st_at_err); end
    total++;
    if (MSG_COUNT !== c0) begin bad++; $display("FAIL underrun_count: got %0d, want %0d", MSG_COUNT, c0); end
  endtask

  task automatic test_reset_mid();
    int b0 = beats;
    int b1;
    logic ok;
    load_len(6);
    for (int i = 0; i < 6; i++) load_word(16'hC000 + 16'(i), i == 0, i == 5);
    for (int i = 0; i < 100; i++) begin
      @(posedge RX_CLK);
      #1;
      if (beats - b0 >= 2) break;
    end
    total++;
    if (state_mon !== 3'd3) begin bad++; $display("FAIL rstmid_pre_state: got %0d, want 3", state_mon); end
    RST = 1'b0;
    #1;
    total++;
    if ({LEN_RDREQ, DATA_RDREQ, TX_VALID, TX_DATA, TX_SOP, TX_EOP, MSG_COUNT,
         ERR_LEN, ERR_UNDERRUN, state_mon} !== 36'd0) begin
      bad++;
      $display("FAIL rstmid_outputs: got nonzero, valid=%b count=%0d state=%0d", TX_VALID, MSG_COUNT, state_mon);
    end
    sb.delete();
    dat_wp = dat_rp;
    len_wp = len_rp;
    repeat (2) @(posedge RX_CLK);
    #1 RST = 1'b1;
    b1 = beats;
    load_len(2);
    load_word(16'hD000, 1'b1, 1'b0);
    load_word(16'hD001, 1'b0, 1'b1);
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_timeout: got not done, want done"); end
    total++;
    if (beats - b1 != 2) begin bad++; $display("FAIL rstmid_beats: got %0d, want 2", beats - b1); end
    total++;
    if (MSG_COUNT !== 8'd1) begin bad++; $display("FAIL rstmid_count: got %0d, want 1", MSG_COUNT); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] start = MSG_COUNT;
    logic [7:0] prev  = MSG_COUNT;
    logic [7:0] want;
    int incs = 0;
    logic wrapped = 1'b0;
    logic ok = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_len(1);
      load_word(16'hE000 + 16'(i), 1'b1, 1'b1);
    end
    for (int i = 0; i < 6000; i++) begin
      @(negedge RX_CLK);
      if (MSG_COUNT !== prev) begin
        want = prev + 8'd1;
        total++;
        if (MSG_COUNT !== want) begin
          bad++;
          $display("FAIL b2b_step: got %0d, want %0d", MSG_COUNT, want);
        end
        if ((prev == 8'd255) && (MSG_COUNT == 8'd0)) wrapped = 1'b1;
        prev = MSG_COUNT;
        incs++;
      end
      if ((sb.size() == 0) && (state_mon == 3'd0) && LEN_EMPTY) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_timeout: got not done, want done"); end
    total++;
    if (incs != 256) begin bad++; $display("FAIL b2b_incs: got %0d, want 256", incs); end
    total++;
    if (!wrapped) begin bad++; $display("FAIL b2b_wrap: got no 255->0 step, want one"); end
    total++;
    if (MSG_COUNT !== start) begin bad++; $display("FAIL b2b_final: got %0d, want %0d", MSG_COUNT, start); end
  endtask

  initial begin
    RST      = 1'b0;
    TX_READY = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_zero_len();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
